// File: rtl/rt_ibex_pcs_ctrl.sv
// ============================================================================
// Module   : rt_ibex_pcs_ctrl
// Purpose  : PCS register-bank save/restore sequencer with LIFO nesting depth
//            and level stack. Optional macro: RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module rt_ibex_pcs_ctrl #(
    parameter int NrEntries     = 8,
    parameter int IrqLevelWidth = 8,
    localparam int AddrWidth    = $clog2(NrEntries)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     irq_ack_i,
    input  logic [IrqLevelWidth-1:0] irq_level_i,
    input  logic                     mret_i,
    input  logic                     err_clr_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic                     restore_valid_o,
    output logic                     busy_o,
    output logic [AddrWidth:0]       depth_o,
    output logic [IrqLevelWidth-1:0] cur_level_o,
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
    output logic                     level_err_o,
`endif
    output logic                     overflow_o,
    output logic                     underflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

    localparam logic [AddrWidth:0] c_one  = (AddrWidth+1)'(1);
    localparam logic [AddrWidth:0] c_full = (AddrWidth+1)'(NrEntries);

    state_e                   r_state;
    logic [AddrWidth:0]       r_depth;
    logic [IrqLevelWidth-1:0] r_stack [NrEntries];
    logic [IrqLevelWidth-1:0] r_save_level;
    logic [IrqLevelWidth-1:0] r_pend_level;
    logic                     r_pend_ack;
    logic                     r_pend_mret;
    logic                     r_mret_first;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [AddrWidth-1:0]     r_mem_addr;
    logic                     r_restore_valid;
    logic                     r_overflow;
    logic                     r_underflow;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
    logic                     r_level_err;
    logic                     w_level_bad;
`endif

    logic [AddrWidth:0]       w_depth_m1;
    logic                     w_full;
    logic                     w_empty;
    logic [IrqLevelWidth-1:0] w_cur_level;
    logic                     w_serve_ack;
    logic                     w_serve_mret;
    logic [IrqLevelWidth-1:0] w_serve_level;
    logic                     w_clr_pend_ack;
    logic                     w_clr_pend_mret;
    logic                     w_latch_ack;
    logic                     w_latch_mret;
    logic                     w_pa_keep;
    logic                     w_pm_keep;

    assign w_depth_m1  = r_depth - c_one;
    assign w_full      = (r_depth == c_full);
    assign w_empty     = (r_depth == '0);
    assign w_cur_level = w_empty ? '0 : r_stack[w_depth_m1[AddrWidth-1:0]];
    assign w_pa_keep   = r_pend_ack && !w_clr_pend_ack;
    assign w_pm_keep   = r_pend_mret && !w_clr_pend_mret;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
    assign w_level_bad = !w_empty && (w_serve_level <= w_cur_level);
`endif

    // Pending events take priority over new ones; new arrivals that cannot be
    // served this cycle go into their type's single pending slot.
    always_comb begin
        w_serve_ack     = 1'b0;
        w_serve_mret    = 1'b0;
        w_serve_level   = irq_level_i;
        w_clr_pend_ack  = 1'b0;
        w_clr_pend_mret = 1'b0;
        w_latch_ack     = 1'b0;
        w_latch_mret    = 1'b0;
        if (r_state == ST_IDLE && !r_pend_ack && !r_pend_mret) begin
            w_serve_ack  = irq_ack_i;
            w_serve_mret = mret_i && !irq_ack_i;
            w_latch_mret = irq_ack_i && mret_i;
        end else begin
            if (r_state == ST_IDLE) begin
                if (r_pend_ack && (!r_pend_mret || !r_mret_first)) begin
                    w_serve_ack    = 1'b1;
                    w_serve_level  = r_pend_level;
                    w_clr_pend_ack = 1'b1;
                end else begin
                    w_serve_mret    = 1'b1;
                    w_clr_pend_mret = 1'b1;
                end
            end
            w_latch_ack  = irq_ack_i && (!r_pend_ack || w_clr_pend_ack);
            w_latch_mret = mret_i && (!r_pend_mret || w_clr_pend_mret);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= ST_IDLE;
            r_depth         <= '0;
            for (int i = 0; i < NrEntries; i++) r_stack[i] <= '0;
            r_save_level    <= '0;
            r_pend_level    <= '0;
            r_pend_ack      <= 1'b0;
            r_pend_mret     <= 1'b0;
            r_mret_first    <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_restore_valid <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
            r_level_err     <= 1'b0;
`endif
        end else begin
            if (w_clr_pend_ack)  r_pend_ack  <= 1'b0;
            if (w_clr_pend_mret) r_pend_mret <= 1'b0;
            if (w_latch_ack) begin
                r_pend_ack   <= 1'b1;
                r_pend_level <= irq_level_i;
            end
            if (w_latch_mret) r_pend_mret <= 1'b1;

            // Arrival order between the two slots; a tie favours the ack.
            if (w_latch_ack && w_latch_mret)  r_mret_first <= 1'b0;
            else if (w_latch_ack && w_pm_keep) r_mret_first <= 1'b1;
            else if (w_latch_mret && w_pa_keep) r_mret_first <= 1'b0;

            if (err_clr_i) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
                r_level_err <= 1'b0;
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_serve_ack) begin
                        if (w_full) r_overflow <= 1'b1;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
                        else if (w_level_bad) r_level_err <= 1'b1;
`endif
                        else begin
                            r_state      <= ST_SAVE;
                            r_save_level <= w_serve_level;
                            r_mem_req    <= 1'b1;
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_depth[AddrWidth-1:0];
                        end
                    end else if (w_serve_mret) begin
                        if (w_empty) r_underflow <= 1'b1;
                        else begin
                            r_state    <= ST_RD_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_depth_m1[AddrWidth-1:0];
                        end
                    end
                end
                ST_SAVE: begin
                    r_mem_req                        <= 1'b0;
                    r_mem_we                         <= 1'b0;
                    r_stack[r_depth[AddrWidth-1:0]]  <= r_save_level;
                    r_depth                          <= r_depth + c_one;
                    r_state                          <= ST_IDLE;
                end
                ST_RD_REQ: begin
                    r_mem_req       <= 1'b0;
                    r_restore_valid <= 1'b1;
                    r_state         <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    r_restore_valid <= 1'b0;
                    r_depth         <= w_depth_m1;
                    r_state         <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o       = r_mem_req;
    assign mem_we_o        = r_mem_we;
    assign mem_addr_o      = r_mem_addr;
    assign restore_valid_o = r_restore_valid;
    assign busy_o          = (r_state != ST_IDLE) | r_pend_ack | r_pend_mret;
    assign depth_o         = r_depth;
    assign cur_level_o     = w_cur_level;
    assign overflow_o      = r_overflow;
    assign underflow_o     = r_underflow;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
    assign level_err_o     = r_level_err;
`endif

endmodule

`default_nettype wire
